// File: rtl/cpu_pkg.sv
// Shared RV32 core constants: datapath width, address width and unified memory depth.
package cpu_pkg;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MEM_DEPTH = 64;
endpackage

// File: rtl/unified_sync_ram.sv
// Single-port unified instruction/data RAM with a one-cycle registered read.
// Read-during-write returns the old word; the array itself is never reset.
module unified_sync_ram
  import cpu_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = ADDR_W,
  parameter int DEPTH    = MEM_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W_P-1:0] addr,
  input  logic                we,
  input  logic [DATA_W_P-1:0] wdata,
  output logic [DATA_W_P-1:0] rdata
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W_P-1:0] mem [DEPTH];
  logic [IDX_W-1:0]    idx;

  // Upper address bits are dropped, so accesses wrap modulo DEPTH.
  assign idx = addr[IDX_W-1:0];

  // Contents survive reset; an unknown we evaluates false and does not write.
  always_ff @(posedge clk) begin
    if (rst_n && we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: tb/tb_unified_sync_ram.sv
// Self-checking bench for unified_sync_ram: directed vector table, reset corner
// cases, and random traffic against an array-based reference memory.
module tb_unified_sync_ram;
  import cpu_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] ref_mem [MEM_DEPTH];
  logic [DATA_W-1:0] exp_rd;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic              w;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp;
    string             name;
  } vec_t;

  vec_t vecs [8];

  unified_sync_ram dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
    end
  endtask

  // One access: drive on the falling edge, sample 1 time unit after the rising
  // edge. exp_rd is what the reference memory held before any write (read-first).
  task automatic step(input logic [ADDR_W-1:0] a, input logic w,
                      input logic [DATA_W-1:0] d);
    int i;
    @(negedge clk);
    addr  = a;
    we    = w;
    wdata = d;
    @(posedge clk);
    #1;
    i = int'(a % MEM_DEPTH);
    exp_rd = ref_mem[i];
    if (w && rst_n) ref_mem[i] = d;
  endtask

  initial begin
    rst_n = 1'b0;
    addr  = '0;
    we    = 1'b0;
    wdata = '0;

    for (int i = 0; i < MEM_DEPTH; i++) begin
      dut.mem[i] = '0;
      ref_mem[i] = '0;
    end
    dut.mem[0] = 32'h0050_0093;  ref_mem[0] = 32'h0050_0093;
    dut.mem[1] = 32'h0030_0113;  ref_mem[1] = 32'h0030_0113;
    dut.mem[7] = 32'h1111_1111;  ref_mem[7] = 32'h1111_1111;

    #1;
    check("reset_rdata", rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{32'd0,  1'b0, 32'h0,         32'h0050_0093, "fetch_pc0"};
    vecs[1] = '{32'd1,  1'b0, 32'h0,         32'h0030_0113, "fetch_pc1"};
    vecs[2] = '{32'd5,  1'b1, 32'hDEAD_BEEF, 32'h0,         "write_5_old"};
    vecs[3] = '{32'd5,  1'b0, 32'h0,         32'hDEAD_BEEF, "read_5"};
    vecs[4] = '{32'd7,  1'b1, 32'h2222_2222, 32'h1111_1111, "rdw_old_7"};
    vecs[5] = '{32'd7,  1'b0, 32'h0,         32'h2222_2222, "rdw_new_7"};
    vecs[6] = '{32'd70, 1'b1, 32'hA5A5_A5A5, 32'h0,         "wrap_write_70"};
    vecs[7] = '{32'd6,  1'b0, 32'h0,         32'hA5A5_A5A5, "wrap_read_6"};

    for (int v = 0; v < 8; v++) begin
      step(vecs[v].a, vecs[v].w, vecs[v].d);
      check(vecs[v].name, rdata, vecs[v].exp);
    end
    check("wrap_backdoor_6", dut.mem[6], 32'hA5A5_A5A5);
    check("wrap_backdoor_7", dut.mem[7], 32'h2222_2222);

    // Reset asserted between edges while a nonzero word is on rdata.
    step(32'd9, 1'b1, 32'h1234_5678);
    step(32'd9, 1'b0, 32'h0);
    check("pre_reset_rdata", rdata, 32'h1234_5678);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_rdata", rdata, 32'h0);
    step(32'd0, 1'b1, 32'hBAD0_BAD0);
    check("reset_hold_rdata", rdata, 32'h0);
    check("reset_no_write", dut.mem[0], 32'h0050_0093);
    @(negedge clk);
    rst_n = 1'b1;
    we    = 1'b0;
    step(32'd0, 1'b0, 32'h0);
    check("post_reset_read0", rdata, 32'h0050_0093);

    // Unknown write enable must not modify the array.
    step(32'd3, 1'bx, 32'hFFFF_0000);
    check("x_we_rdata", rdata, exp_rd);
    check("x_we_no_write", dut.mem[3], ref_mem[3]);

    // Ten read-only cycles with toggling wdata.
    for (int n = 0; n < 10; n++) begin
      step(32'($urandom_range(0, 255)), 1'b0, 32'($urandom));
      check("ro_read", rdata, exp_rd);
    end
    for (int i = 0; i < MEM_DEPTH; i++) check("ro_contents", dut.mem[i], ref_mem[i]);

    // Random mixed traffic, full 32-bit addresses to exercise wrapping.
    for (int n = 0; n < 300; n++) begin
      step(32'($urandom), 1'($urandom_range(0, 1)), 32'($urandom));
      check("rand_read", rdata, exp_rd);
    end
    for (int i = 0; i < MEM_DEPTH; i++) check("rand_contents", dut.mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
